design_switch_controller: RTL and testbench
===========================================

Name: design_switch_controller

Overview:
Parametrised successor to the top-level design selector. It routes GPIO, logic-analyzer, Wishbone and IRQ outputs from one of NUM_PROJECTS student designs to the shared user-area pins. Unlike a purely combinational mux, it performs a safe, sequenced switchover whenever design_select changes: debounce the select, drain any open Wishbone cycle, hold the target design in reset, then release it. It sits between the caravel user-project ports and the per-design wrappers, and replaces the separate reset router.

Parameters:
NUM_PROJECTS, 13, number of designs; design IDs are 1..NUM_PROJECTS, and ID 0 means none.
SEL_W, 4, design_select width; elaboration error if NUM_PROJECTS > 2**SEL_W-1.
GPIO_W, 34, GPIO width per design.
LA_W, 2, logic-analyzer output width per design.
STABLE_CYCLES, 4, cycles design_select must be unchanged before it is acted on (≥1).
RST_CYCLES, 16, cycles the target design is held in reset before release (≥1).
DRAIN_TIMEOUT, 64, maximum cycles to wait for wbs_cyc_i to drop before a forced switch.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
design_select  in  SEL_W  requested design ID
wbs_cyc_i  in  1  Wishbone cycle-active, observed for draining
designs_gpio_out  in  NUM_PROJECTS*GPIO_W  packed; design i occupies slice [(i-1)*GPIO_W +: GPIO_W]
designs_gpio_oeb  in  NUM_PROJECTS*GPIO_W  same packing
designs_la_out  in  NUM_PROJECTS*LA_W  same packing
designs_wbs_dat  in  NUM_PROJECTS*32  same packing
designs_wbs_ack  in  NUM_PROJECTS  bit i-1 belongs to design i
designs_irq  in  NUM_PROJECTS  bit i-1 belongs to design i
designs_n_rst  out  NUM_PROJECTS  active-low per-design reset, registered
designs_ncs  out  NUM_PROJECTS  active-low per-design chip select, registered
gpio_out  out  GPIO_W  routed GPIO data
gpio_oeb  out  GPIO_W  routed output enables
la_data_out  out  LA_W  routed logic-analyzer data
wbs_ack_o  out  1  routed Wishbone ack
wbs_dat_o  out  32  routed Wishbone read data
irq  out  1  routed interrupt
active_design  out  SEL_W  ID currently routed; 0 = none
busy  out  1  high while in DRAIN or HOLD
drain_timeout  out  1  sticky flag, set when a drain timed out

Behaviour:
- Clocking and reset: one clock domain, clk. rst is synchronous and active-high. On rst, all of the following take effect in the same cycle:
  - state=IDLE, active_design=0, target=0, drain_timeout=0
  - designs_n_rst all 0, designs_ncs all 1
  - stability counter cleared
  - rst mid-switch aborts the switch immediately.
- Select sampling: design_select is registered into sel_q every cycle. A stability counter resets whenever sel_q changes and saturates at STABLE_CYCLES. "cand_ok" is asserted when the counter equals STABLE_CYCLES. A candidate is valid if 1 ≤ sel_q ≤ NUM_PROJECTS.
- IDLE:
  - cand_ok and valid, with sel_q differing from active_design → HOLD, target=sel_q, hold counter=RST_CYCLES-1.
  - Invalid sel_q → remain in IDLE.
- ACTIVE: cand_ok and sel_q≠active_design → DRAIN, target=sel_q, drain counter=0.
- DRAIN (old design still routed, still out of reset, still selected):
  - sel_q==active_design and cand_ok → back to ACTIVE (switch aborted).
  - Otherwise, if wbs_cyc_i==0 or drain counter==DRAIN_TIMEOUT-1 → go to HOLD if target is valid, else to IDLE with active_design=0. On a timeout exit, set drain_timeout.
- HOLD:
  - All designs are in reset; target's ncs is low; hold counter decrements.
  - At 0 → ACTIVE, with active_design=target.
  - If a new cand_ok valid value ≠ target arrives → reload the counter and set target to the new value.
  - If a cand_ok invalid value arrives → IDLE.
- Registered control outputs:
  - designs_n_rst[i-1]=1 only when next state is ACTIVE or DRAIN and active_design==i.
  - designs_ncs[i-1]=0 for active_design in ACTIVE/DRAIN, and for target in HOLD; all others 1.
- Output routing (combinational from registered state and active_design, zero latency):
  - In ACTIVE or DRAIN, every routed output equals the corresponding slice of design active_design.
  - In IDLE or HOLD, outputs take safe values: gpio_oeb all ones (inputs), gpio_out 0, la_data_out 0, wbs_ack_o 0, wbs_dat_o 0, irq 0.
- Simultaneous events: rst dominates everything. In DRAIN, abort takes priority over exit.
- busy = (state==DRAIN || state==HOLD).

Decomposition:
- Package design_switch_pkg: state enum (IDLE, ACTIVE, DRAIN, HOLD), counter-width helper function, safe-value constants.
- Sub-module select_debouncer(SEL_W, STABLE_CYCLES): holds sel_q, the stability counter and the cand_ok output.
- FSM and output mux remain in the top module.

Test Plan:
1. rst=1 for 2 cycles, then design_select=3 → designs_ncs[2]=0 after 1+4 cycles; designs_n_rst[2]=1 and active_design=3 after a further 16 cycles; gpio_oeb all ones until then, and equal to design 3's slice afterwards.
2. Active=3, wbs_cyc_i=1, then select=5 → state DRAIN; design 3 stays routed. Drop cyc after 10 cycles → HOLD for 16 cycles → active_design=5, with drain_timeout=0.
3. Same as 2, but wbs_cyc_i is held high → forced switch after 64 cycles; drain_timeout=1 and stays 1 until rst.
4. Active=3, select glitches to 7 for 2 cycles and returns to 3 → no switch; busy stays 0. Select=7 for 4 cycles then 3 for 4 cycles while in DRAIN → abort to ACTIVE with design 3, whose reset never dropped.
5. Select=0 or select=14 (NUM_PROJECTS=13) from active 2 → after drain, IDLE with active_design=0; all designs_n_rst=0, all outputs safe.
6. rst asserted mid-HOLD → next cycle IDLE with all designs in reset; after rst release with select=3 stable, the full 4+16 sequence restarts.

Source files
------------

// File: rtl/design_switch_pkg.sv
// Shared types, constants and helpers for the design switch controller.
package design_switch_pkg;

  // Switchover sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Values driven onto the shared pins while no design is routed:
  // GPIOs become inputs, every data/strobe line is held low.
  localparam logic        SAFE_OEB_BIT  = 1'b1;
  localparam logic        SAFE_DATA_BIT = 1'b0;
  localparam logic [31:0] SAFE_WB_DAT   = 32'h0000_0000;

  // Number of bits needed to hold the value max_val (at least 1).
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    for (int b = 1; b < 31; b++) begin
      if ((1 << b) <= max_val) w = b + 1;
    end
    return w;
  endfunction

  // True when id names a real design (IDs start at 1, 0 means none).
  function automatic logic id_in_range(input int id, input int num_projects);
    return (id >= 1) && (id <= num_projects);
  endfunction

endpackage

// File: rtl/design_switch_controller_select_debouncer.sv
// Registers the requested design ID and reports when it has been stable
// long enough to be acted on.
module select_debouncer
  import design_switch_pkg::*;
#(
  parameter int SEL_W         = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] i_sel,
  output logic [SEL_W-1:0] o_sel_q,
  output logic             o_cand_ok
);

  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_SAT = CW'(STABLE_CYCLES);

  logic [SEL_W-1:0] r_sel_q;
  logic [CW-1:0]    r_stable_cnt;

  // Capture the select every cycle; the capture cycle of a new value counts
  // as its first stable cycle, and the count saturates at STABLE_CYCLES.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel_q      <= '0;
      r_stable_cnt <= '0;
    end else begin
      r_sel_q <= i_sel;
      if (i_sel != r_sel_q) begin
        r_stable_cnt <= CW'(1);
      end else if (r_stable_cnt != CNT_SAT) begin
        r_stable_cnt <= r_stable_cnt + CW'(1);
      end
    end
  end

  assign o_sel_q   = r_sel_q;
  assign o_cand_ok = (r_stable_cnt == CNT_SAT);

endmodule

// File: rtl/design_switch_controller.sv
// Routes one of NUM_PROJECTS student designs to the shared user-area pins and
// sequences every change of selection: debounce, drain Wishbone, hold the new
// design in reset, then release and route it.
module design_switch_controller
  import design_switch_pkg::*;
#(
  parameter int NUM_PROJECTS  = 13,
  parameter int SEL_W         = 4,
  parameter int GPIO_W        = 34,
  parameter int LA_W          = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int RST_CYCLES    = 16,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SEL_W-1:0]           design_select,
  input  logic                       wbs_cyc_i,
  input  logic [NUM_PROJECTS*GPIO_W-1:0] designs_gpio_out,
  input  logic [NUM_PROJECTS*GPIO_W-1:0] designs_gpio_oeb,
  input  logic [NUM_PROJECTS*LA_W-1:0]   designs_la_out,
  input  logic [NUM_PROJECTS*32-1:0]     designs_wbs_dat,
  input  logic [NUM_PROJECTS-1:0]    designs_wbs_ack,
  input  logic [NUM_PROJECTS-1:0]    designs_irq,
  output logic [NUM_PROJECTS-1:0]    designs_n_rst,
  output logic [NUM_PROJECTS-1:0]    designs_ncs,
  output logic [GPIO_W-1:0]          gpio_out,
  output logic [GPIO_W-1:0]          gpio_oeb,
  output logic [LA_W-1:0]            la_data_out,
  output logic                       wbs_ack_o,
  output logic [31:0]                wbs_dat_o,
  output logic                       irq,
  output logic [SEL_W-1:0]           active_design,
  output logic                       busy,
  output logic                       drain_timeout
);

  localparam int NUM_IDS = 2 ** SEL_W;
  localparam int HOLD_W  = cnt_width(RST_CYCLES - 1);
  localparam int DRAIN_W = cnt_width(DRAIN_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(RST_CYCLES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_TIMEOUT - 1);

  // Reject parameter sets the ID encoding or the sequencer cannot honour.
  generate
    if (NUM_PROJECTS > NUM_IDS - 1) begin : g_bad_num_projects
      $error("NUM_PROJECTS does not fit in SEL_W bits with ID 0 reserved");
    end
    if (STABLE_CYCLES < 1 || RST_CYCLES < 1 || DRAIN_TIMEOUT < 1) begin : g_bad_cycles
      $error("STABLE_CYCLES, RST_CYCLES and DRAIN_TIMEOUT must all be >= 1");
    end
  endgenerate

  logic [SEL_W-1:0] w_sel_q;
  logic             w_cand_ok;
  logic             w_sel_valid;
  logic             w_target_valid;

  state_t             r_state, w_state_next;
  logic [SEL_W-1:0]   r_active, w_active_next;
  logic [SEL_W-1:0]   r_target, w_target_next;
  logic [HOLD_W-1:0]  r_hold_cnt, w_hold_cnt_next;
  logic [DRAIN_W-1:0] r_drain_cnt, w_drain_cnt_next;
  logic               r_drain_timeout, w_drain_timeout_next;
  logic [NUM_PROJECTS-1:0] r_n_rst, w_n_rst_next;
  logic [NUM_PROJECTS-1:0] r_ncs, w_ncs_next;
  logic               w_run_next;

  select_debouncer #(
    .SEL_W        (SEL_W),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_select_debouncer (
    .clk      (clk),
    .rst      (rst),
    .i_sel    (design_select),
    .o_sel_q  (w_sel_q),
    .o_cand_ok(w_cand_ok)
  );

  assign w_sel_valid    = id_in_range(int'(w_sel_q), NUM_PROJECTS);
  assign w_target_valid = id_in_range(int'(r_target), NUM_PROJECTS);

  // Sequencer state, counters and registered per-design reset/select lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_active        <= '0;
      r_target        <= '0;
      r_hold_cnt      <= '0;
      r_drain_cnt     <= '0;
      r_drain_timeout <= 1'b0;
      r_n_rst         <= '0;
      r_ncs           <= '1;
    end else begin
      r_state         <= w_state_next;
      r_active        <= w_active_next;
      r_target        <= w_target_next;
      r_hold_cnt      <= w_hold_cnt_next;
      r_drain_cnt     <= w_drain_cnt_next;
      r_drain_timeout <= w_drain_timeout_next;
      r_n_rst         <= w_n_rst_next;
      r_ncs           <= w_ncs_next;
    end
  end

  // Next-state logic; active_design is cleared whenever the old design stops
  // being routed so that it always names what is on the pins.
  always_comb begin
    w_state_next         = r_state;
    w_active_next        = r_active;
    w_target_next        = r_target;
    w_hold_cnt_next      = r_hold_cnt;
    w_drain_cnt_next     = r_drain_cnt;
    w_drain_timeout_next = r_drain_timeout;
    case (r_state)
      ST_IDLE: begin
        if (w_cand_ok && w_sel_valid && (w_sel_q != r_active)) begin
          w_state_next    = ST_HOLD;
          w_target_next   = w_sel_q;
          w_hold_cnt_next = HOLD_LOAD;
        end
      end
      ST_ACTIVE: begin
        if (w_cand_ok && (w_sel_q != r_active)) begin
          w_state_next     = ST_DRAIN;
          w_target_next    = w_sel_q;
          w_drain_cnt_next = '0;
        end
      end
      ST_DRAIN: begin
        if (w_cand_ok && (w_sel_q == r_active)) begin
          // Request returned to the running design: abandon the switch.
          w_state_next = ST_ACTIVE;
        end else if (!wbs_cyc_i || (r_drain_cnt == DRAIN_LAST)) begin
          if (wbs_cyc_i) w_drain_timeout_next = 1'b1;
          w_active_next = '0;
          if (w_target_valid) begin
            w_state_next    = ST_HOLD;
            w_hold_cnt_next = HOLD_LOAD;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_drain_cnt_next = r_drain_cnt + DRAIN_W'(1);
        end
      end
      ST_HOLD: begin
        if (w_cand_ok && !w_sel_valid) begin
          w_state_next = ST_IDLE;
        end else if (w_cand_ok && (w_sel_q != r_target)) begin
          w_target_next   = w_sel_q;
          w_hold_cnt_next = HOLD_LOAD;
        end else if (r_hold_cnt == '0) begin
          w_state_next  = ST_ACTIVE;
          w_active_next = r_target;
        end else begin
          w_hold_cnt_next = r_hold_cnt - HOLD_W'(1);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_run_next = (w_state_next == ST_ACTIVE) || (w_state_next == ST_DRAIN);

  // Per-design reset release and chip select, derived from the next state so
  // the registered lines line up with the state they describe.
  generate
    for (genvar gi = 0; gi < NUM_PROJECTS; gi++) begin : g_ctrl
      localparam logic [SEL_W-1:0] ID = SEL_W'(gi + 1);
      assign w_n_rst_next[gi] = w_run_next && (w_active_next == ID);
      assign w_ncs_next[gi]   = ~((w_run_next && (w_active_next == ID)) ||
                                  ((w_state_next == ST_HOLD) && (w_target_next == ID)));
    end
  endgenerate

  // Unpacked per-ID views of the design buses; entry 0 and unused IDs carry
  // the safe values so the mux can never expose an undriven slice.
  logic [GPIO_W-1:0] w_gpio_out_arr [NUM_IDS];
  logic [GPIO_W-1:0] w_gpio_oeb_arr [NUM_IDS];
  logic [LA_W-1:0]   w_la_arr       [NUM_IDS];
  logic [31:0]       w_dat_arr      [NUM_IDS];
  logic              w_ack_arr      [NUM_IDS];
  logic              w_irq_arr      [NUM_IDS];

  generate
    for (genvar gi = 0; gi < NUM_IDS; gi++) begin : g_route
      if (gi >= 1 && gi <= NUM_PROJECTS) begin : g_real
        assign w_gpio_out_arr[gi] = designs_gpio_out[(gi-1)*GPIO_W +: GPIO_W];
        assign w_gpio_oeb_arr[gi] = designs_gpio_oeb[(gi-1)*GPIO_W +: GPIO_W];
        assign w_la_arr[gi]       = designs_la_out[(gi-1)*LA_W +: LA_W];
        assign w_dat_arr[gi]      = designs_wbs_dat[(gi-1)*32 +: 32];
        assign w_ack_arr[gi]      = designs_wbs_ack[gi-1];
        assign w_irq_arr[gi]      = designs_irq[gi-1];
      end else begin : g_safe
        assign w_gpio_out_arr[gi] = {GPIO_W{SAFE_DATA_BIT}};
        assign w_gpio_oeb_arr[gi] = {GPIO_W{SAFE_OEB_BIT}};
        assign w_la_arr[gi]       = {LA_W{SAFE_DATA_BIT}};
        assign w_dat_arr[gi]      = SAFE_WB_DAT;
        assign w_ack_arr[gi]      = SAFE_DATA_BIT;
        assign w_irq_arr[gi]      = SAFE_DATA_BIT;
      end
    end
  endgenerate

  logic             w_route;
  logic [SEL_W-1:0] w_route_id;

  assign w_route    = (r_state == ST_ACTIVE) || (r_state == ST_DRAIN);
  assign w_route_id = w_route ? r_active : '0;

  assign gpio_out      = w_gpio_out_arr[w_route_id];
  assign gpio_oeb      = w_gpio_oeb_arr[w_route_id];
  assign la_data_out   = w_la_arr[w_route_id];
  assign wbs_dat_o     = w_dat_arr[w_route_id];
  assign wbs_ack_o     = w_ack_arr[w_route_id];
  assign irq           = w_irq_arr[w_route_id];

  assign designs_n_rst = r_n_rst;
  assign designs_ncs   = r_ncs;
  assign active_design = r_active;
  assign busy          = (r_state == ST_DRAIN) || (r_state == ST_HOLD);
  assign drain_timeout = r_drain_timeout;

endmodule

// File: tb/tb_design_switch_controller.sv
// Scoreboard bench: stimulus queues the expected control-state changes with
// the cycle they must appear on; a monitor pops one entry per observed change.
module tb_design_switch_controller;

  localparam int NP = 13;
  localparam int SW = 4;
  localparam int GW = 34;
  localparam int LW = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [SW-1:0]      design_select;
  logic               wbs_cyc_i;
  logic [NP*GW-1:0]   designs_gpio_out;
  logic [NP*GW-1:0]   designs_gpio_oeb;
  logic [NP*LW-1:0]   designs_la_out;
  logic [NP*32-1:0]   designs_wbs_dat;
  logic [NP-1:0]      designs_wbs_ack;
  logic [NP-1:0]      designs_irq;
  logic [NP-1:0]      designs_n_rst;
  logic [NP-1:0]      designs_ncs;
  logic [GW-1:0]      gpio_out;
  logic [GW-1:0]      gpio_oeb;
  logic [LW-1:0]      la_data_out;
  logic               wbs_ack_o;
  logic [31:0]        wbs_dat_o;
  logic               irq;
  logic [SW-1:0]      active_design;
  logic               busy;
  logic               drain_timeout;

  design_switch_controller dut (
    .clk             (clk),
    .rst             (rst),
    .design_select   (design_select),
    .wbs_cyc_i       (wbs_cyc_i),
    .designs_gpio_out(designs_gpio_out),
    .designs_gpio_oeb(designs_gpio_oeb),
    .designs_la_out  (designs_la_out),
    .designs_wbs_dat (designs_wbs_dat),
    .designs_wbs_ack (designs_wbs_ack),
    .designs_irq     (designs_irq),
    .designs_n_rst   (designs_n_rst),
    .designs_ncs     (designs_ncs),
    .gpio_out        (gpio_out),
    .gpio_oeb        (gpio_oeb),
    .la_data_out     (la_data_out),
    .wbs_ack_o       (wbs_ack_o),
    .wbs_dat_o       (wbs_dat_o),
    .irq             (irq),
    .active_design   (active_design),
    .busy            (busy),
    .drain_timeout   (drain_timeout)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    string         name;
    int            cyc;
    logic [SW-1:0] act;
    logic          busy;
    logic          tout;
    logic [NP-1:0] nrst;
    logic [NP-1:0] ncs;
    int            route;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  bit   mon_en = 1'b0;

  // Per-design data patterns; route 0 gives the safe values.
  function automatic logic [GW-1:0] pat_gpio(int i);
    if (i == 0) return '0;
    return {2'b10, 8'hC3, 16'h0000, 8'(i)};
  endfunction
  function automatic logic [GW-1:0] pat_oeb(int i);
    if (i == 0) return '1;
    return {2'b01, 8'h3C, 16'hF0F0, 8'(i)};
  endfunction
  function automatic logic [LW-1:0] pat_la(int i);
    if (i == 0) return '0;
    return LW'(i);
  endfunction
  function automatic logic [31:0] pat_dat(int i);
    if (i == 0) return 32'h0;
    return 32'hD00D_0000 | 32'(i);
  endfunction
  function automatic logic pat_ack(int i);
    return (i != 0);
  endfunction
  function automatic logic pat_irq(int i);
    return (i != 0) && (i % 2 == 1);
  endfunction

  function automatic logic [NP-1:0] onehot(int id);
    logic [NP-1:0] m;
    m = '0;
    if (id >= 1) m[id-1] = 1'b1;
    return m;
  endfunction

  task automatic expect_ev(string name, int cyc, int act, bit b, bit tout,
                           int nrst_id, int ncs_id, int route);
    exp_t e;
    e.name  = name;
    e.cyc   = cyc;
    e.act   = SW'(act);
    e.busy  = b;
    e.tout  = tout;
    e.nrst  = onehot(nrst_id);
    e.ncs   = ~onehot(ncs_id);
    e.route = route;
    exp_q.push_back(e);
  endtask

  task automatic chk(string name, string field, logic [63:0] got, logic [63:0] want);
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s.%s got=%0h want=%0h", name, field, got, want);
    end
  endtask

  // Monitor: any change of the control outputs is one transaction.
  initial begin
    logic [SW+2+2*NP-1:0] prev;
    logic [SW+2+2*NP-1:0] snap;
    exp_t e;
    prev = 'x;
    wait (mon_en);
    forever begin
      @(posedge clk);
      #1;
      snap = {active_design, busy, drain_timeout, designs_n_rst, designs_ncs};
      if (snap !== prev) begin
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_event cyc=%0d got act=%0d busy=%0b tout=%0b nrst=%0h ncs=%0h want no change",
                   cyc_cnt, active_design, busy, drain_timeout, designs_n_rst, designs_ncs);
        end else begin
          e = exp_q.pop_front();
          n_vec++;
          $display("ev %s cyc=%0d act=%0d busy=%0b tout=%0b nrst=%0h ncs=%0h oeb=%0h",
                   e.name, cyc_cnt, active_design, busy, drain_timeout,
                   designs_n_rst, designs_ncs, gpio_oeb);
          chk(e.name, "cycle",    64'(cyc_cnt),        64'(e.cyc));
          chk(e.name, "active",   64'(active_design),  64'(e.act));
          chk(e.name, "busy",     64'(busy),           64'(e.busy));
          chk(e.name, "timeout",  64'(drain_timeout),  64'(e.tout));
          chk(e.name, "n_rst",    64'(designs_n_rst),  64'(e.nrst));
          chk(e.name, "ncs",      64'(designs_ncs),    64'(e.ncs));
          chk(e.name, "gpio_out", 64'(gpio_out),       64'(pat_gpio(e.route)));
          chk(e.name, "gpio_oeb", 64'(gpio_oeb),       64'(pat_oeb(e.route)));
          chk(e.name, "la",       64'(la_data_out),    64'(pat_la(e.route)));
          chk(e.name, "wb_dat",   64'(wbs_dat_o),      64'(pat_dat(e.route)));
          chk(e.name, "wb_ack",   64'(wbs_ack_o),      64'(pat_ack(e.route)));
          chk(e.name, "irq",      64'(irq),            64'(pat_irq(e.route)));
        end
      end
      prev = snap;
    end
  end

  // Wait (bounded) for all queued events, then a few quiet cycles.
  task automatic wait_drain(int limit);
    exp_t e;
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_miss++;
      $display("FAIL %s.missing got=none by cyc %0d want event at cyc %0d", e.name, cyc_cnt, e.cyc);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=no finish want=finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst           = 1'b1;
    design_select = '0;
    wbs_cyc_i     = 1'b0;
    for (int i = 1; i <= NP; i++) begin
      designs_gpio_out[(i-1)*GW +: GW] = pat_gpio(i);
      designs_gpio_oeb[(i-1)*GW +: GW] = pat_oeb(i);
      designs_la_out[(i-1)*LW +: LW]   = pat_la(i);
      designs_wbs_dat[(i-1)*32 +: 32]  = pat_dat(i);
      designs_wbs_ack[i-1]             = pat_ack(i);
      designs_irq[i-1]                 = pat_irq(i);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);

    // 1: power-up selection of design 3.
    c = cyc_cnt; rst = 1'b0; design_select = 4'd3; mon_en = 1'b1;
    expect_ev("t1_reset",  c + 1,  0, 0, 0, 0, 0, 0);
    expect_ev("t1_hold",   c + 5,  0, 1, 0, 0, 3, 0);
    expect_ev("t1_active", c + 21, 3, 0, 0, 3, 3, 3);
    wait_drain(40);

    // 2: 3 -> 5 with an open Wishbone cycle that closes normally.
    c = cyc_cnt; wbs_cyc_i = 1'b1; design_select = 4'd5;
    expect_ev("t2_drain", c + 5, 3, 1, 0, 3, 3, 3);
    wait_drain(20);
    repeat (6) @(negedge clk);
    c = cyc_cnt; wbs_cyc_i = 1'b0;
    expect_ev("t2_hold",   c + 1,  0, 1, 0, 0, 5, 0);
    expect_ev("t2_active", c + 17, 5, 0, 0, 5, 5, 5);
    wait_drain(30);

    // 3: 5 -> 3 with Wishbone stuck busy: forced switch after the timeout.
    c = cyc_cnt; wbs_cyc_i = 1'b1; design_select = 4'd3;
    expect_ev("t3_drain",  c + 5,  5, 1, 0, 5, 5, 5);
    expect_ev("t3_forced", c + 69, 0, 1, 1, 0, 3, 0);
    expect_ev("t3_active", c + 85, 3, 0, 1, 3, 3, 3);
    wait_drain(100);

    // 4: short glitch is ignored; a longer excursion drains and aborts.
    design_select = 4'd7;
    repeat (2) @(negedge clk);
    design_select = 4'd3;
    repeat (12) @(negedge clk);
    c = cyc_cnt; design_select = 4'd7;
    expect_ev("t4_drain", c + 5, 3, 1, 1, 3, 3, 3);
    expect_ev("t4_abort", c + 9, 3, 0, 1, 3, 3, 3);
    repeat (4) @(negedge clk);
    design_select = 4'd3;
    wait_drain(20);

    // 5: move to design 2, then deselect with 0 and with out-of-range 14.
    c = cyc_cnt; wbs_cyc_i = 1'b0; design_select = 4'd2;
    expect_ev("t5_drain",  c + 5,  3, 1, 1, 3, 3, 3);
    expect_ev("t5_hold",   c + 6,  0, 1, 1, 0, 2, 0);
    expect_ev("t5_active", c + 22, 2, 0, 1, 2, 2, 2);
    wait_drain(40);
    c = cyc_cnt; design_select = 4'd0;
    expect_ev("t5_drain0", c + 5, 2, 1, 1, 2, 2, 2);
    expect_ev("t5_idle0",  c + 6, 0, 0, 1, 0, 0, 0);
    wait_drain(20);
    c = cyc_cnt; design_select = 4'd2;
    expect_ev("t5_hold2",   c + 5,  0, 1, 1, 0, 2, 0);
    expect_ev("t5_active2", c + 21, 2, 0, 1, 2, 2, 2);
    wait_drain(40);
    c = cyc_cnt; design_select = 4'd14;
    expect_ev("t5_drain14", c + 5, 2, 1, 1, 2, 2, 2);
    expect_ev("t5_idle14",  c + 6, 0, 0, 1, 0, 0, 0);
    wait_drain(20);

    // 6: reset in the middle of HOLD, then the full sequence again.
    c = cyc_cnt; design_select = 4'd3;
    expect_ev("t6_hold", c + 5, 0, 1, 1, 0, 3, 0);
    repeat (10) @(negedge clk);
    c = cyc_cnt; rst = 1'b1;
    expect_ev("t6_reset", c + 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    c = cyc_cnt; rst = 1'b0;
    expect_ev("t6_hold_again", c + 5,  0, 1, 0, 0, 3, 0);
    expect_ev("t6_active",     c + 21, 3, 0, 0, 3, 3, 3);
    wait_drain(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
